fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the decode stage.
- Generates fetch PCs and issues one request at a time on a SRAM-like instruction bus.
- Holds the returned instruction in a one-entry output buffer and hands {inst, pc} to decode with a valid/allowin handshake.
- Consumes decode's br_bus: redirects the PC and squashes every wrong-path fetch, whether buffered, in flight or not yet issued.

---
 rtl/fetch_stage_pkg.sv | 18 +
 rtl/fetch_stage_if.sv | 28 ++
 rtl/fetch_stage.sv | 136 +++++++++++++
 tb/tb_fetch_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared widths and encodings for the instruction-fetch stage.
//   FS_TO_DS_BUS_WD : width of {inst, pc} handed to decode
//   BR_BUS_WD       : width of {br_taken, br_target} coming back from decode
//   SRAM_SIZE_WORD  : size code for a 32-bit access on the instruction bus
//   out_st_e        : outstanding-request state (IDLE / WAIT)
package fetch_stage_pkg;

  localparam int FS_TO_DS_BUS_WD = 64;
  localparam int BR_BUS_WD       = 33;

  localparam logic [1:0] SRAM_SIZE_WORD = 2'd2;

  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_WAIT = 1'b1
  } out_st_e;

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: SRAM-like instruction bus between the fetch stage and memory.
//   master (fetch side) : drives req/wr/size/wstrb/addr/wdata, receives addr_ok/data_ok/rdata
//   slave  (memory side): the reverse
interface fetch_stage_if;

  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  modport master (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
  );

  modport slave (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
  );

endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage feeding decode.
//   clk            : clock, rising edge
//   reset          : asynchronous, active-low
//   ds_allowin     : decode can take an instruction this cycle
//   br_bus         : {br_taken, br_target} from decode
//   fs_to_ds_valid : fs_to_ds_bus holds a correct-path instruction
//   fs_to_ds_bus   : {inst, pc}
//   inst_sram      : instruction bus (master side), one request outstanding at most
//   debug_if_pc    : PC of the buffered instruction
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  fetch_stage_if.master              inst_sram,
  output logic [31:0]                debug_if_pc
);

  logic        br_taken;
  logic [31:0] br_target;
  assign {br_taken, br_target} = br_bus;

  logic [31:0] nxt_pc_q,    nxt_pc_d;
  logic        br_pend_q,   br_pend_d;
  logic [31:0] br_target_q, br_target_d;
  out_st_e     out_st_q,    out_st_d;
  logic        cancel_q,    cancel_d;
  logic [31:0] req_pc_q,    req_pc_d;
  logic        fs_valid_q,  fs_valid_d;
  logic [31:0] fs_inst_q,   fs_inst_d;
  logic [31:0] fs_pc_q,     fs_pc_d;

  logic        can_issue;
  logic [31:0] fetch_addr;
  logic        req_fire;
  logic        handoff;

  // A pending redirect takes priority over the sequential PC.
  assign fetch_addr = br_pend_q ? br_target_q : nxt_pc_q;

  // Issue only when nothing is outstanding, no redirect is arriving, and the
  // buffer is empty or draining this cycle, so the reply can always land.
  assign can_issue = (out_st_q == OUT_IDLE) && !br_taken && (!fs_valid_q || ds_allowin);

  // Request is gated by reset so nothing is presented while held in reset.
  assign inst_sram.inst_sram_req   = reset && can_issue;
  assign inst_sram.inst_sram_wr    = 1'b0;
  assign inst_sram.inst_sram_size  = SRAM_SIZE_WORD;
  assign inst_sram.inst_sram_wstrb = 4'h0;
  assign inst_sram.inst_sram_addr  = fetch_addr;
  assign inst_sram.inst_sram_wdata = 32'h0;

  assign req_fire = inst_sram.inst_sram_req && inst_sram.inst_sram_addr_ok;

  // Masking with br_taken keeps a wrong-path instruction out of decode in the
  // very cycle the branch resolves.
  assign fs_to_ds_valid = fs_valid_q && !br_taken;
  assign fs_to_ds_bus   = {fs_inst_q, fs_pc_q};
  assign debug_if_pc    = fs_pc_q;
  assign handoff        = fs_to_ds_valid && ds_allowin;

  always_comb begin
    nxt_pc_d    = nxt_pc_q;
    br_pend_d   = br_pend_q;
    br_target_d = br_target_q;
    out_st_d    = out_st_q;
    cancel_d    = cancel_q;
    req_pc_d    = req_pc_q;
    fs_valid_d  = fs_valid_q;
    fs_inst_d   = fs_inst_q;
    fs_pc_d     = fs_pc_q;

    if (req_fire) begin
      out_st_d  = OUT_WAIT;
      req_pc_d  = fetch_addr;
      nxt_pc_d  = fetch_addr + 32'd4;
      br_pend_d = 1'b0;
    end

    if (handoff) begin
      fs_valid_d = 1'b0;
    end

    if (inst_sram.inst_sram_data_ok) begin
      out_st_d = OUT_IDLE;
      if (cancel_q || br_taken) begin
        cancel_d = 1'b0;
      end else begin
        fs_valid_d = 1'b1;
        fs_inst_d  = inst_sram.inst_sram_rdata;
        fs_pc_d    = req_pc_q;
      end
    end

    // Redirect is idempotent while decode holds br_taken across stalls.
    if (br_taken) begin
      br_pend_d   = 1'b1;
      br_target_d = br_target;
      fs_valid_d  = 1'b0;
      if (out_st_q == OUT_WAIT && !inst_sram.inst_sram_data_ok) begin
        cancel_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nxt_pc_q    <= RESET_PC;
      br_pend_q   <= 1'b0;
      br_target_q <= 32'h0;
      out_st_q    <= OUT_IDLE;
      cancel_q    <= 1'b0;
      req_pc_q    <= 32'h0;
      fs_valid_q  <= 1'b0;
      fs_inst_q   <= 32'h0;
      fs_pc_q     <= 32'h0;
    end else begin
      nxt_pc_q    <= nxt_pc_d;
      br_pend_q   <= br_pend_d;
      br_target_q <= br_target_d;
      out_st_q    <= out_st_d;
      cancel_q    <= cancel_d;
      req_pc_q    <= req_pc_d;
      fs_valid_q  <= fs_valid_d;
      fs_inst_q   <= fs_inst_d;
      fs_pc_q     <= fs_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam int NUM_CYCLES = 3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ds_allowin;
  logic [32:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic [31:0] debug_if_pc;

  fetch_stage_if sram_if();

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (rst_n),
    .ds_allowin     (ds_allowin),
    .br_bus         (br_bus),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .inst_sram      (sram_if),
    .debug_if_pc    (debug_if_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  bit mon_en = 1'b0;

  // Memory content: every word address holds a distinct, address-derived word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5AF00D;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: the expected next correct-path PC sits at the queue front.
  initial begin
    logic        prev_hold;
    logic [31:0] e;
    prev_hold = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      if (!mon_en || !rst_n) begin
        prev_hold = 1'b0;
        continue;
      end
      if (br_bus[32]) begin
        chk("no_req_during_branch", {63'd0, sram_if.inst_sram_req}, 64'd0);
        chk("valid_masked_by_branch", {63'd0, fs_to_ds_valid}, 64'd0);
      end else if (prev_hold) begin
        chk("hold_valid", {63'd0, fs_to_ds_valid}, 64'd1);
      end
      if (fs_to_ds_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instruction: got pc %h with nothing expected", fs_to_ds_bus[31:0]);
        end else begin
          e = exp_q[0];
          chk("fs_to_ds_bus", fs_to_ds_bus, {mem_word(e), e});
          chk("debug_if_pc", {32'd0, debug_if_pc}, {32'd0, e});
          if (ds_allowin) void'(exp_q.pop_front());
        end
      end
      prev_hold = fs_to_ds_valid && !ds_allowin;
    end
  end

  // Memory slave state
  bit          m_pend = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_addr = 32'h0;
  bit          fast = 1'b0;

  task automatic mem_drive();
    sram_if.inst_sram_data_ok = m_pend && (m_cnt == 1);
    sram_if.inst_sram_rdata   = sram_if.inst_sram_data_ok ? mem_word(m_addr) : $urandom;
    sram_if.inst_sram_addr_ok = sram_if.inst_sram_req && !m_pend &&
                                (fast || ($urandom_range(0, 9) < 6));
  endtask

  initial begin
    int          br_cnt, nb_cnt, idle, deliveries, early;
    bit          s_req, s_aok, s_hand, did_reset;
    logic [31:0] s_addr, br_tgt, model_pc;

    br_cnt = 0; nb_cnt = 0; idle = 0; deliveries = 0; early = 0; did_reset = 1'b0;
    br_tgt = 32'h0;
    model_pc = RESET_PC;
    ds_allowin = 1'b1;
    br_bus = 33'd0;
    sram_if.inst_sram_addr_ok = 1'b0;
    sram_if.inst_sram_data_ok = 1'b0;
    sram_if.inst_sram_rdata   = 32'h0;

    #12;
    chk("reset_req", {63'd0, sram_if.inst_sram_req}, 64'd0);
    chk("reset_valid", {63'd0, fs_to_ds_valid}, 64'd0);
    chk("reset_bus", fs_to_ds_bus, 64'd0);
    chk("reset_debug_pc", {32'd0, debug_if_pc}, 64'd0);
    chk("const_wr", {63'd0, sram_if.inst_sram_wr}, 64'd0);
    chk("const_size", {62'd0, sram_if.inst_sram_size}, 64'd2);
    chk("const_wstrb", {60'd0, sram_if.inst_sram_wstrb}, 64'd0);
    chk("const_wdata", {32'd0, sram_if.inst_sram_wdata}, 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(RESET_PC);
    mon_en = 1'b1;

    for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
      fast = (cyc < 20);
      // decode side
      if (br_cnt > 0) br_bus = {1'b1, br_tgt};
      else            br_bus = {1'b0, 32'($urandom)};
      ds_allowin = fast ? 1'b1 : ($urandom_range(0, 99) < 75);
      #1;
      mem_drive();
      #1;
      s_req  = sram_if.inst_sram_req;
      s_aok  = sram_if.inst_sram_addr_ok;
      s_addr = sram_if.inst_sram_addr;
      s_hand = fs_to_ds_valid && ds_allowin;
      nb_cnt = 0;
      if (s_hand) begin
        deliveries++;
        idle = 0;
        if (fast) early++;
        if (!fast && $urandom_range(0, 3) == 0) begin
          nb_cnt = $urandom_range(1, 4);
          br_tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : (32'($urandom) & 32'hFFFF_FFFC);
          model_pc = br_tgt;
        end else begin
          model_pc = model_pc + 32'd4;
        end
        exp_q.push_back(model_pc);
      end else begin
        idle++;
      end
      if (idle > 300) begin
        checks++;
        errors++;
        $display("FAIL watchdog: no instruction delivered for %0d cycles, required progress", idle);
        break;
      end

      @(posedge clk);
      if (m_pend) begin
        if (m_cnt == 1) m_pend = 1'b0;
        else            m_cnt--;
      end else if (s_req && s_aok) begin
        m_pend = 1'b1;
        m_addr = s_addr;
        m_cnt  = fast ? 1 : $urandom_range(1, 3);
      end
      if (br_cnt > 0) br_cnt--;
      if (nb_cnt > 0) br_cnt = nb_cnt;

      if (cyc == 20) chk("throughput_first_20", 64'(early), 64'd9);

      if (cyc >= 1500 && !did_reset && m_pend) begin
        // Asynchronous reset while a request is outstanding.
        did_reset = 1'b1;
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset_req", {63'd0, sram_if.inst_sram_req}, 64'd0);
        chk("midreset_valid", {63'd0, fs_to_ds_valid}, 64'd0);
        chk("midreset_bus", fs_to_ds_bus, 64'd0);
        chk("midreset_debug_pc", {32'd0, debug_if_pc}, 64'd0);
        m_pend = 1'b0;
        br_cnt = 0;
        br_bus = 33'd0;
        sram_if.inst_sram_addr_ok = 1'b0;
        sram_if.inst_sram_data_ok = 1'b0;
        exp_q.delete();
        model_pc = RESET_PC;
        exp_q.push_back(RESET_PC);
        idle = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
      end else begin
        @(negedge clk);
      end
    end

    chk("enough_deliveries", {63'd0, deliveries >= 200}, 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
